// File: rtl/jk_updown_counter_pkg.sv
// Shared definitions for the JK up/down counter: per-bit JK command encodings
// and the parameter range check used at elaboration.
package jk_updown_counter_pkg;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_RST  = 2'b01,
        JK_SET  = 2'b10,
        JK_TGL  = 2'b11
    } jk_cmd_e;

    // WIDTH must lie in 2..16 and MAX_COUNT must fit in WIDTH bits.
    function automatic bit params_ok(input int unsigned width,
                                     input int unsigned max_count);
        return (width >= 2) && (width <= 16) && (max_count < (32'd1 << width));
    endfunction

endpackage

// File: rtl/jk_updown_counter_cell.sv
// Single JK storage cell: async active-low reset to 0, Q <= J&~Q | ~K&Q.
module jk_cell
    import jk_updown_counter_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic i_j,
    input  logic i_k,
    output logic o_q
);

    logic    r_q;
    jk_cmd_e w_cmd;

    assign w_cmd = jk_cmd_e'({i_j, i_k});
    assign o_q   = r_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= 1'b0;
        end else begin
            unique case (w_cmd)
                JK_HOLD: r_q <= r_q;
                JK_RST:  r_q <= 1'b0;
                JK_SET:  r_q <= 1'b1;
                JK_TGL:  r_q <= ~r_q;
                default: r_q <= r_q;
            endcase
        end
    end

endmodule

// File: rtl/jk_updown_counter.sv
// Modulo-(MAX_COUNT+1) up/down counter built from per-bit JK cells, with
// parallel load (clamped), terminal-count detection and a registered wrap pulse.
module jk_updown_counter
    import jk_updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_COUNT = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic [WIDTH-1:0] jk_j,
    output logic [WIDTH-1:0] jk_k
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

    if (!params_ok(WIDTH, MAX_COUNT)) begin : g_bad_params
        $error("jk_updown_counter: WIDTH must be 2..16 and MAX_COUNT < 2**WIDTH");
    end

    logic [WIDTH-1:0] w_target;
    logic [WIDTH-1:0] w_inc_mask;
    logic [WIDTH-1:0] w_dec_mask;
    logic             w_at_top;
    logic             w_at_bot;
    logic             w_inc_carry;
    logic             w_dec_borrow;
    logic             r_wrap;

    assign w_target = (load_val > MAX_V) ? MAX_V : load_val;

    // Out-of-range values are folded into the wrap cases so an upset count
    // recovers on the next enabled edge and still reports a wrap.
    assign w_at_top = (count >= MAX_V);
    assign w_at_bot = (count == '0) || (count > MAX_V);

    assign tc = en & ~load & ((up & w_at_top) | (~up & w_at_bot));

    // Toggle masks: bit i toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        w_inc_mask   = '0;
        w_dec_mask   = '0;
        w_inc_carry  = 1'b1;
        w_dec_borrow = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_inc_mask[i] = w_inc_carry;
            w_dec_mask[i] = w_dec_borrow;
            w_inc_carry   = w_inc_carry & count[i];
            w_dec_borrow  = w_dec_borrow & ~count[i];
        end
    end

    always_comb begin
        jk_j = '0;
        jk_k = '0;
        if (load) begin
            jk_j = w_target;
            jk_k = ~w_target;
        end else if (en) begin
            if (up) begin
                if (w_at_top) begin
                    jk_j = '0;
                    jk_k = '1;
                end else begin
                    jk_j = w_inc_mask;
                    jk_k = w_inc_mask;
                end
            end else begin
                if (w_at_bot) begin
                    jk_j = MAX_V;
                    jk_k = ~MAX_V;
                end else begin
                    jk_j = w_dec_mask;
                    jk_k = w_dec_mask;
                end
            end
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cells
        jk_cell u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .i_j     (jk_j[gi]),
            .i_k     (jk_k[gi]),
            .o_q     (count[gi])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= tc;
        end
    end

    assign wrap = r_wrap;

endmodule
